// File: rtl/dac_pkg.sv
// Shared definitions for the DAC frame scheduler.
//   DAC_BITS    : width of one DAC word
//   CNT_SCK_W   : width of the bit-index output handed to the serial driver
//   CNT_SCK_END : bit-index value once all DAC_BITS bits have been clocked
//   dac_state_t : frame sequencer states
package dac_pkg;

  localparam int DAC_BITS  = 16;
  localparam int CNT_SCK_W = 5;
  localparam logic [CNT_SCK_W-1:0] CNT_SCK_END = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SHIFT     = 3'd2,
    S_CS_HOLD   = 3'd3,
    S_LDAC_WAIT = 3'd4,
    S_DONE      = 3'd5
  } dac_state_t;

endpackage

// File: rtl/dac_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : per-channel request levels
//   rr_ptr : highest-priority channel for this decision
//   enable : gates the valid flag
//   grant  : first requesting channel at or after rr_ptr (cyclic)
//   valid  : enable and at least one request present
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int CHW  = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CHW-1:0]  rr_ptr,
  input  logic            enable,
  output logic [CHW-1:0]  grant,
  output logic            valid
);

  logic [CHW-1:0] hi_idx;
  logic           hi_ok;
  logic [CHW-1:0] lo_idx;
  logic           lo_ok;

  // Scanning downwards leaves the lowest matching index in each result:
  // hi_* is the lowest request at or above rr_ptr, lo_* the lowest overall,
  // which is the wrap-around winner when nothing sits at or above rr_ptr.
  always_comb begin
    hi_idx = '0;
    hi_ok  = 1'b0;
    lo_idx = '0;
    lo_ok  = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_idx = CHW'(k);
        lo_ok  = 1'b1;
        if (CHW'(k) >= rr_ptr) begin
          hi_idx = CHW'(k);
          hi_ok  = 1'b1;
        end
      end
    end
    valid = enable && lo_ok;
    grant = hi_ok ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Round-robin scheduler sharing one serial DAC driver among N_CH channels.
// Each grant runs one frame: LOAD (en_dac pulse, cs low), SHIFT (16 sck
// periods of 2*SCK_DIV clk), CS_HOLD (SCK_DIV clk), LDAC_WAIT (LDAC_WAIT
// clk with cs high), DONE (ack pulse).
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_state   : global enable; low aborts the frame and returns to idle
//   req/data_in : per-channel request levels and 16-bit words
//   ack         : one-cycle pulse to the served channel
//   busy        : high from LOAD through DONE
//   ch_sel      : channel being served
//   data_sdi    : latched word for the driver, stable for the frame
//   en_dac, cs, sck, cnt_sck : driver control
//   state_dbg   : current sequencer state (dac_state_t encoding)
// Handshake: a channel holds req high until it sees its ack pulse; req is
// sampled only in IDLE, so dropping it mid-frame neither aborts nor
// suppresses the ack.
module dac_frame_scheduler
  import dac_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CHW       = 2,
  parameter int SCK_DIV   = 2,
  parameter int LDAC_WAIT = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_state,
  input  logic [N_CH-1:0]          req,
  input  logic [DAC_BITS*N_CH-1:0] data_in,
  output logic [N_CH-1:0]          ack,
  output logic                     busy,
  output logic [CHW-1:0]           ch_sel,
  output logic [DAC_BITS-1:0]      data_sdi,
  output logic                     en_dac,
  output logic                     cs,
  output logic                     sck,
  output logic [CNT_SCK_W-1:0]     cnt_sck,
  output logic [2:0]               state_dbg
);

  localparam int DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int WAIT_W = (LDAC_WAIT > 1) ? $clog2(LDAC_WAIT) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LDAC_WAIT - 1);
  localparam logic [CNT_SCK_W-1:0] LAST_BIT = CNT_SCK_END - 5'd1;

  dac_state_t            state_q, state_d;
  logic [CHW-1:0]        ch_sel_q, ch_sel_d;
  logic [CHW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DAC_BITS-1:0]   data_q, data_d;
  logic                  sck_q, sck_d;
  logic [CNT_SCK_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;

  logic [CHW-1:0]        gnt_idx;
  logic                  gnt_valid;
  logic [DAC_BITS-1:0]   gnt_data;

  rr_arbiter #(
    .N_CH (N_CH),
    .CHW  (CHW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .enable (key_state && (state_q == S_IDLE)),
    .grant  (gnt_idx),
    .valid  (gnt_valid)
  );

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx == CHW'(k)) gnt_data = data_in[k*DAC_BITS +: DAC_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ch_sel_q <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      sck_q    <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_sel_q <= ch_sel_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      sck_q    <= sck_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      wait_q   <= wait_d;
    end
  end

  // Counters only advance while below their terminal value, so they can
  // never wrap inside a frame.
  always_comb begin
    state_d  = state_q;
    ch_sel_d = ch_sel_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    sck_d    = sck_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    wait_d   = wait_q;
    if (!key_state) begin
      // Abort: idle the driver lines; rr_ptr keeps its value.
      state_d = S_IDLE;
      data_d  = '0;
      sck_d   = 1'b0;
      cnt_d   = '0;
      div_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            state_d  = S_LOAD;
            ch_sel_d = gnt_idx;
            data_d   = gnt_data;
            sck_d    = 1'b0;
            cnt_d    = '0;
            div_d    = '0;
          end
        end
        S_LOAD: begin
          state_d = S_SHIFT;
          sck_d   = 1'b0;
          cnt_d   = '0;
          div_d   = '0;
        end
        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (!sck_q) begin
              sck_d = 1'b1;
            end else begin
              // Falling edge advances the bit index; after the last bit's
              // high half the index parks at CNT_SCK_END.
              sck_d = 1'b0;
              if (cnt_q == LAST_BIT) begin
                cnt_d   = CNT_SCK_END;
                state_d = S_CS_HOLD;
              end else begin
                cnt_d = cnt_q + 5'd1;
              end
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        S_CS_HOLD: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            wait_d  = '0;
            state_d = S_LDAC_WAIT;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        S_LDAC_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_DONE: begin
          state_d  = S_IDLE;
          rr_ptr_d = (ch_sel_q == CHW'(N_CH - 1)) ? '0 : ch_sel_q + CHW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign en_dac    = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign cs        = !((state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_CS_HOLD));
  assign sck       = sck_q;
  assign cnt_sck   = cnt_q;
  assign data_sdi  = data_q;
  assign ch_sel    = ch_sel_q;
  assign state_dbg = state_q;
  // Gated by key_state so an abort landing on DONE yields no ack, matching
  // the rr_ptr update that the abort also suppresses.
  assign ack = ((state_q == S_DONE) && key_state) ? (N_CH'(1) << ch_sel_q) : '0;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
module tb_dac_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_state = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] data_in = '0;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  ch_sel;
  logic [15:0] data_sdi;
  logic        en_dac, cs, sck;
  logic [4:0]  cnt_sck;
  logic [2:0]  state_dbg;

  logic [3:0]  req1 = '0;
  logic [63:0] data1 = '0;
  logic [3:0]  ack1;
  logic        busy1;
  logic [1:0]  ch_sel1;
  logic [15:0] data_sdi1;
  logic        en_dac1, cs1, sck1;
  logic [4:0]  cnt_sck1;
  logic [2:0]  state_dbg1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [17:0] exp_q[$];
  logic [15:0] d[4];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dac_frame_scheduler #(.N_CH(4), .CHW(2), .SCK_DIV(2), .LDAC_WAIT(10)) dut (
    .clk(clk), .rst_n(rst_n), .key_state(key_state), .req(req), .data_in(data_in),
    .ack(ack), .busy(busy), .ch_sel(ch_sel), .data_sdi(data_sdi), .en_dac(en_dac),
    .cs(cs), .sck(sck), .cnt_sck(cnt_sck), .state_dbg(state_dbg));

  dac_frame_scheduler #(.N_CH(4), .CHW(2), .SCK_DIV(1), .LDAC_WAIT(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .key_state(1'b1), .req(req1), .data_in(data1),
    .ack(ack1), .busy(busy1), .ch_sel(ch_sel1), .data_sdi(data_sdi1), .en_dac(en_dac1),
    .cs(cs1), .sck(sck1), .cnt_sck(cnt_sck1), .state_dbg(state_dbg1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_en(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (en_dac) return;
    end
    timeout(tag);
  endtask

  // Waits for an ack and drops the served channel's request, as a requester would.
  task automatic wait_ack(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (|ack) begin
        for (int k = 0; k < 4; k++) if (ack[k]) req[k] = 1'b0;
        return;
      end
    end
    timeout(tag);
  endtask

  // ---------------- scoreboard / monitor for dut ----------------
  logic        in_frame = 1'b0;
  logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_en = 1'b0, prev_ack = 1'b0;
  int          load_cyc = 0, nbits = 0, cs_low = 0, last_rise = 0;
  logic [15:0] word = '0;
  logic [17:0] e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (!busy) in_frame = 1'b0;
      if (en_dac) begin
        chk("en_dac_single", {31'd0, prev_en}, 32'd0);
        in_frame = 1'b1;
        load_cyc = cyc;
        word = '0;
        nbits = 0;
        cs_low = 0;
      end
      if (in_frame && !cs) cs_low++;
      if (in_frame && sck && !prev_sck) begin
        chk("cnt_at_rise", {27'd0, cnt_sck}, nbits);
        if (nbits > 0) chk("sck_period", cyc - last_rise, 32'd4);
        last_rise = cyc;
        word = {word[14:0], data_sdi[4'd15 - cnt_sck[3:0]]};
        nbits++;
      end
      if (in_frame && cs && !prev_cs && busy) chk("cnt_after_shift", {27'd0, cnt_sck}, 32'd16);
      if (|ack) begin
        chk("ack_single", {31'd0, prev_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", {28'd0, ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_ch", {28'd0, ack}, 32'd1 << e[17:16]);
          chk("ch_sel", {30'd0, ch_sel}, {30'd0, e[17:16]});
          chk("shift_word", {16'd0, word}, {16'd0, e[15:0]});
          chk("data_hold", {16'd0, data_sdi}, {16'd0, e[15:0]});
          chk("frame_len", cyc - load_cyc + 1, 32'd78);
          chk("cs_low_len", cs_low, 32'd67);
          chk("nbits", nbits, 32'd16);
          chk("cnt_done", {27'd0, cnt_sck}, 32'd0);
        end
        in_frame = 1'b0;
      end
    end
    prev_sck = sck;
    prev_cs  = cs;
    prev_en  = en_dac;
    prev_ack = |ack;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int len, rises, last1;
    logic p_sck1;
    bit got;

    for (int k = 0; k < 4; k++) d[k] = 16'($urandom_range(0, 65535));
    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, cs}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cs", {31'd0, cs}, 32'd1);
    chk("idle_sck", {31'd0, sck}, 32'd0);
    chk("idle_cnt", {27'd0, cnt_sck}, 32'd0);
    chk("idle_en", {31'd0, en_dac}, 32'd0);
    chk("idle_data", {16'd0, data_sdi}, 32'd0);
    chk("idle_ack", {28'd0, ack}, 32'd0);
    chk("idle_chsel", {30'd0, ch_sel}, 32'd0);
    chk("idle_state", {29'd0, state_dbg}, {29'd0, dac_pkg::S_IDLE});

    // Single request, known word.
    d[0] = 16'hA5C3;
    data_in = {d[3], d[2], d[1], d[0]};
    exp_q.push_back({2'd0, 16'hA5C3});
    req = 4'b0001;
    wait_ack("t1_ack");

    // Reset returns rr_ptr to 0, then round-robin over 1011.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({2'd0, d[0]});
    exp_q.push_back({2'd1, d[1]});
    exp_q.push_back({2'd3, d[3]});
    exp_q.push_back({2'd0, d[0]});
    req = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      wait_ack("rr_ack");
      if (i == 3) begin
        req = 4'b0000;
      end else begin
        @(negedge clk);
        req = 4'b1011;
      end
    end

    // rr_ptr=1: ch2 moves it to 3, then 1001 serves ch3 then ch0 (wrap).
    exp_q.push_back({2'd2, d[2]});
    req = 4'b0100;
    wait_ack("ch2_ack");
    exp_q.push_back({2'd3, d[3]});
    exp_q.push_back({2'd0, d[0]});
    req = 4'b1001;
    wait_en("ch3_load");
    repeat (20) @(negedge clk);
    data_in[63:48] = ~d[3];
    wait_ack("ch3_ack");
    wait_ack("ch0_ack");

    // Abort at bit 7 with rr_ptr=1; ch1 must restart, then ch0.
    data_in[63:48] = d[3];
    exp_q.push_back({2'd1, d[1]});
    exp_q.push_back({2'd0, d[0]});
    req = 4'b0011;
    wait_en("abort_load");
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (cnt_sck == 5'd7) got = 1'b1;
    end
    if (!got) timeout("abort_bit7");
    key_state = 1'b0;
    @(negedge clk);
    chk("abort_cs", {31'd0, cs}, 32'd1);
    chk("abort_sck", {31'd0, sck}, 32'd0);
    chk("abort_cnt", {27'd0, cnt_sck}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ack", {28'd0, ack}, 32'd0);
    chk("abort_data", {16'd0, data_sdi}, 32'd0);
    chk("abort_state", {29'd0, state_dbg}, {29'd0, dac_pkg::S_IDLE});
    key_state = 1'b1;
    wait_en("restart_load");
    chk("restart_ch", {30'd0, ch_sel}, 32'd1);
    chk("restart_cnt", {27'd0, cnt_sck}, 32'd0);
    wait_ack("restart_ack");
    wait_ack("after_abort_ack");
    req = 4'b0000;

    // Asynchronous reset mid-frame, applied between clock edges.
    req = 4'b0100;
    wait_en("areset_load");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("areset_cs", {31'd0, cs}, 32'd1);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_sck", {31'd0, sck}, 32'd0);
    chk("areset_cnt", {27'd0, cnt_sck}, 32'd0);
    chk("areset_data", {16'd0, data_sdi}, 32'd0);
    chk("areset_ack", {28'd0, ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SCK_DIV=1, LDAC_WAIT=12 instance: 47-clk frame, 2-clk sck period.
    data1 = {16'h0, 16'($urandom_range(0, 65535)), 32'h0};
    req1 = 4'b0100;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (en_dac1) got = 1'b1;
    end
    if (!got) timeout("sweep_load");
    len = 1;
    rises = 0;
    last1 = 0;
    p_sck1 = sck1;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      len++;
      if (sck1 && !p_sck1) begin
        if (rises > 0) chk("sweep_sck_period", len - last1, 32'd2);
        last1 = len;
        rises++;
      end
      p_sck1 = sck1;
      if (|ack1) begin
        got = 1'b1;
        req1 = 4'b0000;
      end
    end
    if (!got) timeout("sweep_ack");
    chk("sweep_frame_len", len, 32'd47);
    chk("sweep_ack", {28'd0, ack1}, 32'h4);
    chk("sweep_rises", rises, 32'd16);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
